// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with a bounded hold time per grant.
// A grant lasts while the owner keeps requesting, up to MAX_HOLD cycles.
// Every grant is followed by at least one idle (GAP) cycle. Arbitration
// resumes one position past the most recent winner.
module rr_hold_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 en,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 busy,
  output logic                 timeout
);

  localparam int unsigned   IW         = $clog2(N);
  localparam int unsigned   CW         = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_LIMIT = CW'(MAX_HOLD);
  localparam logic [IW-1:0] LAST_RST   = IW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    GAP   = 2'b10
  } state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  gnt_nxt;
  logic [IW-1:0] gnt_id_nxt;
  logic [IW-1:0] last, last_nxt;
  logic [CW-1:0] hold_cnt, hold_nxt;
  logic          timeout_nxt;
  logic [IW-1:0] win;
  logic          found;
  int unsigned   idx;

  // Winner search: first set request bit upward from last+1, wrapping.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (32'(last) + k) % N;
      if (!found && req[IW'(idx)]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  // Next-state and registered-output values.
  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    gnt_id_nxt  = gnt_id;
    last_nxt    = last;
    hold_nxt    = hold_cnt;
    timeout_nxt = 1'b0;
    case (state)
      IDLE, GAP: begin
        gnt_nxt = '0;
        if (en && found) begin
          state_nxt     = GRANT;
          gnt_nxt[win]  = 1'b1;
          gnt_id_nxt    = win;
          last_nxt      = win;
          hold_nxt      = CW'(1);
        end else begin
          state_nxt = IDLE;
        end
      end
      GRANT: begin
        // gnt_id always names the current owner while in GRANT.
        if (req[gnt_id] && (hold_cnt < HOLD_LIMIT)) begin
          hold_nxt = hold_cnt + CW'(1);
        end else begin
          state_nxt   = GAP;
          gnt_nxt     = '0;
          timeout_nxt = req[gnt_id];
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      hold_cnt <= '0;
      last     <= LAST_RST;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      gnt_id   <= gnt_id_nxt;
      busy     <= |gnt_nxt;
      timeout  <= timeout_nxt;
      hold_cnt <= hold_nxt;
      last     <= last_nxt;
    end
  end

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Self-checking bench for rr_hold_arbiter: directed scenarios followed by
// random traffic, all compared against a behavioural owner/run-length model.
module tb_rr_hold_arbiter;

  localparam int unsigned N        = 4;
  localparam int unsigned MAX_HOLD = 8;
  localparam int unsigned IW       = $clog2(N);

  logic          clk;
  logic          resetn;
  logic          en;
  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_id;
  logic          busy;
  logic          timeout;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: who owns the resource, for how long, and who won last.
  int m_owner;
  int m_len;
  int m_last;
  int m_gid;
  bit m_tmo;

  rr_hold_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .en      (en),
    .req     (req),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_owner = -1;
    m_len   = 0;
    m_last  = N - 1;
    m_gid   = 0;
    m_tmo   = 1'b0;
  endtask

  function automatic int pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last + k) % N;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [N-1:0] r, input logic e);
    int w;
    m_tmo = 1'b0;
    if (m_owner >= 0) begin
      if (r[m_owner] && m_len < MAX_HOLD) begin
        m_len++;
      end else begin
        m_tmo   = r[m_owner];
        m_owner = -1;
      end
    end else if (e) begin
      w = pick(r, m_last);
      if (w >= 0) begin
        m_owner = w;
        m_last  = w;
        m_gid   = w;
        m_len   = 1;
      end
    end
  endtask

  task automatic check(input string tag);
    logic [N-1:0]  eg;
    logic [IW-1:0] eid;
    eg = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    eid = IW'(m_gid);
    n_tests++;
    assert (gnt === eg) else begin
      n_fail++;
      $error("FAIL %s gnt got %b exp %b", tag, gnt, eg);
    end
    n_tests++;
    assert (gnt_id === eid) else begin
      n_fail++;
      $error("FAIL %s gnt_id got %0d exp %0d", tag, gnt_id, eid);
    end
    n_tests++;
    assert (busy === (m_owner >= 0)) else begin
      n_fail++;
      $error("FAIL %s busy got %b exp %b", tag, busy, (m_owner >= 0));
    end
    n_tests++;
    assert (timeout === m_tmo) else begin
      n_fail++;
      $error("FAIL %s timeout got %b exp %b", tag, timeout, m_tmo);
    end
  endtask

  task automatic cycle(input logic [N-1:0] r, input logic e, input string tag);
    @(negedge clk);
    req = r;
    en  = e;
    @(posedge clk);
    model_step(r, e);
    #1 check(tag);
  endtask

  initial begin
    logic [N-1:0] r;
    logic         e;

    resetn = 1'b1;
    en     = 1'b0;
    req    = '0;
    #1 resetn = 1'b0;
    model_reset();
    #1 check("reset_async");
    @(posedge clk);
    #1 check("reset_held");

    // Priority after reset: all requesting, each holds MAX_HOLD then yields.
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 4 * (MAX_HOLD + 1) + 3; i++) cycle(4'b1111, 1'b1, "prio_all");
    for (int i = 0; i < 3; i++) cycle(4'b0000, 1'b1, "drain");

    // Voluntary release keeps gnt_id.
    for (int i = 0; i < 3; i++) cycle(4'b0100, 1'b1, "vol_hold");
    for (int i = 0; i < 3; i++) cycle(4'b0000, 1'b1, "vol_rel");

    // Fairness after timeout: req[3] joins while requester 1 holds.
    cycle(4'b0010, 1'b1, "fair_start");
    for (int i = 0; i < MAX_HOLD + 3; i++) cycle(4'b1010, 1'b1, "fair_run");
    for (int i = 0; i < 3; i++) cycle(4'b0000, 1'b1, "drain");

    // Enable gating, then en low during a grant.
    for (int i = 0; i < 3; i++) cycle(4'b0011, 1'b0, "en_low");
    cycle(4'b0011, 1'b1, "en_rise");
    for (int i = 0; i < 3; i++) cycle(4'b0011, 1'b0, "en_low_grant");
    for (int i = 0; i < 3; i++) cycle(4'b0000, 1'b0, "drain");

    // Mid-grant asynchronous reset.
    cycle(4'b0010, 1'b1, "pre_rst");
    cycle(4'b0010, 1'b1, "pre_rst");
    #2 resetn = 1'b0;
    model_reset();
    #1 check("mid_grant_rst");
    @(negedge clk);
    resetn = 1'b1;
    req    = 4'b0011;
    en     = 1'b1;
    @(posedge clk);
    model_step(4'b0011, 1'b1);
    #1 check("post_rst");
    for (int i = 0; i < 3; i++) cycle(4'b0000, 1'b1, "drain");

    // Back-to-back grants to the same requester.
    for (int i = 0; i < 2; i++) cycle(4'b0100, 1'b1, "b2b_a");
    cycle(4'b0000, 1'b1, "b2b_drop");
    for (int i = 0; i < 3; i++) cycle(4'b0100, 1'b1, "b2b_b");
    cycle(4'b0100, 1'b1, "b2b_c");

    // Random traffic with sticky requests so grants run for a while.
    r = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) r = N'($urandom_range(0, (1 << N) - 1));
      e = ($urandom_range(0, 5) != 0);
      cycle(r, e, "random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
